multiport_regfile: RTL
======================

// Module: multiport_regfile
// PURPOSE
//  Parametrised multi-port register file: NUM_RD read ports, NUM_WR write ports,
//  byte-enable writes, optional write-to-read bypass, optional hardwired-zero entry 0
//  and optional registered reads. Adds a sequenced clear engine that zeros one entry per cycle.
//  Sits beside the datapath as the general-purpose register store (e.g. 32x32, 2R/1W or 4R/2W).
// PARAMETERS
//  DEPTH     8  number of entries; power of two, >=2
//  WIDTH     8  bits per entry; multiple of 8
//  NUM_RD    2  read ports, >=1
//  NUM_WR    1  write ports, 1..4
//  ZERO_REG  0  1: entry 0 always reads 0 and ignores writes/clear
//  BYPASS    1  1: a read of an address written this cycle returns the new data
//  READ_REG  0  0: combinational read; 1: read data registered (1-cycle latency)
//  AW = $clog2(DEPTH), BW = WIDTH/8 (localparams)
// PORTS
//  clk        in   1              clock; one clock domain, all logic on rising edge
//  rst        in   1              reset; synchronous, active-high
//  wr_en      in   [NUM_WR]       per-port write enable
//  wr_addr    in   [NUM_WR][AW]   write address
//  wr_be      in   [NUM_WR][BW]   byte enables; bit b covers data[8b+7:8b]
//  wr_data    in   [NUM_WR][WIDTH] write data
//  rd_en      in   [NUM_RD]       read enable (used only when READ_REG=1)
//  rd_addr    in   [NUM_RD][AW]   read address
//  rd_data    out  [NUM_RD][WIDTH] read data
//  clr_start  in   1              pulse: begin sequenced clear of all entries
//  clr_busy   out  1              high while clear engine runs
//  clr_done   out  1              one-cycle pulse when clear completes
// BEHAVIOUR
//  Reset: all entries <= 0; rd_data <= 0; clr_busy <= 0; clr_done <= 0; FSM -> IDLE.
//  Write: at posedge, entry[wr_addr[p]] byte b <= wr_data[p] byte b iff wr_en[p] & wr_be[p][b].
//  Same-address multi-port write: per byte, highest-index port with be set wins.
//  ZERO_REG=1: writes to addr 0 dropped; reads of addr 0 return 0 (also via bypass).
//  Read READ_REG=0: rd_data[r] = entry[rd_addr[r]] combinationally, same cycle.
//  Read READ_REG=1: rd_data[r] updated at posedge when rd_en[r]; holds when rd_en[r]=0.
//  BYPASS=1: the value read (comb. output or value captured into register) is the merged
//   post-write value, bytewise, using the same port priority; BYPASS=0 returns pre-write value.
//  Clear FSM: IDLE --clr_start--> CLEAR (idx=0); CLEAR: entry[idx] <= 0, idx++;
//   idx==DEPTH-1 -> IDLE, clr_done=1 for the following cycle. Clear takes exactly DEPTH cycles;
//   clr_busy high the cycle after clr_start through the cycle clearing DEPTH-1.
//  During CLEAR: all wr_en ignored; reads return current (partially cleared) contents, bypass off.
//  clr_start while busy: ignored. clr_start same cycle as writes in IDLE: writes land, then clear.
//  rst mid-clear: everything zeroed, FSM -> IDLE, no clr_done pulse.
//  Address counter wraps nowhere: idx stops at DEPTH-1; out-of-range not possible (power-of-two).
// STRUCTURE
//  Package regfile_pkg: typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t; byte-merge function
//   merge_be(old, new, be) shared by write path and bypass.
//  Sub-module regfile_clear_fsm (state, idx counter, busy/done); storage, write merge, read
//   muxes and bypass in top. Storage: logic [WIDTH-1:0] mem [DEPTH].
// TESTING
//  1 rst, write 0xA5 to addr 3 be=1, next cycle read addr 3 (READ_REG=0) -> rd_data=0xA5.
//  2 NUM_WR=2, WIDTH=16: p0 writes 0x1111 be=11, p1 writes 0x2222 be=10 to addr 5 -> entry=0x2211.
//  3 BYPASS=1: write 0x3C to addr 2 while reading addr 2 -> same-cycle rd_data=0x3C; BYPASS=0 -> old.
//  4 ZERO_REG=1: write 0xFF to addr 0 -> read addr 0 = 0x00; addr 1 unaffected.
//  5 fill DEPTH=8 with 0x11..0x88, pulse clr_start -> busy 8 cycles, done pulse, all reads 0;
//    writes issued while busy absent afterwards.
//  6 READ_REG=1: rd_en=1 addr 4 (0x44) -> rd_data=0x44 next cycle; rd_en=0 -> holds; rst mid-clear
//    -> busy=0, no done, all entries 0.

Source files
------------

// File: rtl/multiport_regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    // Clear engine states.
    typedef enum logic {
        CLR_IDLE,
        CLR_RUN
    } clr_state_t;

    // Widest entry the shared merge helper handles; callers zero-extend into it
    // and truncate the result back to their own WIDTH.
    localparam int MAX_WIDTH = 256;
    localparam int MAX_BW    = MAX_WIDTH / 8;

    // Byte-wise merge: bytes whose enable is set take new_v, the rest keep old_v.
    // Used by both the write path and the bypass path so they cannot disagree.
    function automatic logic [MAX_WIDTH-1:0] merge_be(
        input logic [MAX_WIDTH-1:0] old_v,
        input logic [MAX_WIDTH-1:0] new_v,
        input logic [MAX_BW-1:0]    be
    );
        logic [MAX_WIDTH-1:0] res;
        res = old_v;
        for (int b = 0; b < MAX_BW; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/multiport_regfile_if.sv
// Bundle of write, read and clear-control signals of the register file.
// master = client driving requests, slave = the register file itself.
interface multiport_regfile_if #(
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 8,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = WIDTH / 8;

    logic [NUM_WR-1:0]            wr_en;
    logic [NUM_WR-1:0][AW-1:0]    wr_addr;
    logic [NUM_WR-1:0][BW-1:0]    wr_be;
    logic [NUM_WR-1:0][WIDTH-1:0] wr_data;

    logic [NUM_RD-1:0]            rd_en;
    logic [NUM_RD-1:0][AW-1:0]    rd_addr;
    logic [NUM_RD-1:0][WIDTH-1:0] rd_data;

    logic                         clr_start;
    logic                         clr_busy;
    logic                         clr_done;

    modport master (
        output wr_en, wr_addr, wr_be, wr_data,
        output rd_en, rd_addr,
        output clr_start,
        input  rd_data, clr_busy, clr_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_be, wr_data,
        input  rd_en, rd_addr,
        input  clr_start,
        output rd_data, clr_busy, clr_done
    );

endinterface

// File: rtl/multiport_regfile_clear_fsm.sv
// Sequenced clear engine: walks idx from 0 to DEPTH-1, one entry per cycle,
// then pulses done for one cycle. Start requests while running are ignored.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_start_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [$clog2(DEPTH)-1:0] idx_o
);
    localparam int AW = $clog2(DEPTH);

    clr_state_t    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          done_q, done_d;

    // State, index and done registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: registers take <= so every flop samples pre-edge values no matter how blocks are ordered.
        if (rst) begin
            state_q <= CLR_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: start from IDLE, stop after clearing the last entry.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latch).
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            CLR_IDLE: begin
                if (clr_start_i) begin
                    state_d = CLR_RUN;
                    idx_d   = '0;
                end
            end
            CLR_RUN: begin
                if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = CLR_IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = CLR_IDLE;
        endcase
    end

    assign busy_o = (state_q == CLR_RUN);
    assign done_o = done_q;
    assign idx_o  = idx_q;

endmodule

// File: rtl/multiport_regfile.sv
// Multi-port register file with byte-enable writes, optional write-to-read
// bypass, optional hardwired-zero entry 0, optional registered reads and a
// sequenced clear engine.
module multiport_regfile
    import regfile_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 8,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1,
    parameter bit READ_REG = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    multiport_regfile_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = WIDTH / 8;

    logic [WIDTH-1:0]             mem [DEPTH];
    logic                         clr_busy;
    logic                         clr_done;
    logic [AW-1:0]                clr_idx;
    logic [NUM_WR-1:0]            wr_act;
    logic [NUM_WR-1:0][WIDTH-1:0] wr_val;
    logic [NUM_RD-1:0][WIDTH-1:0] rd_val;

    regfile_clear_fsm #(
        .DEPTH (DEPTH)
    ) u_clear_fsm (
        .clk         (clk),
        .rst         (rst),
        .clr_start_i (bus.clr_start),
        .busy_o      (clr_busy),
        .done_o      (clr_done),
        .idx_o       (clr_idx)
    );

    assign bus.clr_busy = clr_busy;
    assign bus.clr_done = clr_done;

    // Effective write strobes: gated while clearing and, with ZERO_REG, for entry 0.
    always_comb begin
        for (int p = 0; p < NUM_WR; p++) begin
            wr_act[p] = bus.wr_en[p] && !clr_busy &&
                        !(ZERO_REG && (bus.wr_addr[p] == '0));
        end
    end

    // Post-write value per write port: fold in every active port hitting the
    // same address in index order, so higher ports win per byte and all ports
    // sharing an address commit identical data.
    always_comb begin
        for (int p = 0; p < NUM_WR; p++) begin
            wr_val[p] = mem[bus.wr_addr[p]];
            for (int q = 0; q < NUM_WR; q++) begin
                if (wr_act[q] && (bus.wr_addr[q] == bus.wr_addr[p])) begin
                    wr_val[p] = WIDTH'(merge_be(MAX_WIDTH'(wr_val[p]),
                                                MAX_WIDTH'(bus.wr_data[q]),
                                                MAX_BW'(bus.wr_be[q])));
                end
            end
        end
    end

    // Storage update: reset, clear engine, or merged port writes.
    always_ff @(posedge clk) begin
        // NOTE: the array is reset explicitly, so it maps to flops rather than a RAM macro.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_busy) begin
            mem[clr_idx] <= '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_act[p]) begin
                    mem[bus.wr_addr[p]] <= wr_val[p];
                end
            end
        end
    end

    // Read value per port: stored entry, optionally merged with this cycle's
    // writes (bypass is naturally off while clearing since wr_act is gated).
    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            rd_val[r] = mem[bus.rd_addr[r]];
            if (BYPASS) begin
                for (int q = 0; q < NUM_WR; q++) begin
                    if (wr_act[q] && (bus.wr_addr[q] == bus.rd_addr[r])) begin
                        rd_val[r] = WIDTH'(merge_be(MAX_WIDTH'(rd_val[r]),
                                                    MAX_WIDTH'(bus.wr_data[q]),
                                                    MAX_BW'(bus.wr_be[q])));
                    end
                end
            end
            if (ZERO_REG && (bus.rd_addr[r] == '0)) begin
                rd_val[r] = '0;
            end
        end
    end

    generate
        if (READ_REG) begin : g_read_reg
            logic [NUM_RD-1:0][WIDTH-1:0] rd_q;

            // Registered read data: capture on rd_en, hold otherwise.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_q <= '0;
                end else begin
                    for (int r = 0; r < NUM_RD; r++) begin
                        if (bus.rd_en[r]) begin
                            rd_q[r] <= rd_val[r];
                        end
                    end
                end
            end

            assign bus.rd_data = rd_q;
        end else begin : g_read_comb
            // rd_en has no meaning for combinational reads.
            logic unused_rd_en;
            assign unused_rd_en = ^bus.rd_en;
            assign bus.rd_data  = rd_val;
        end
    endgenerate

endmodule
